imem_loader: RTL

- Writer side of the processor's instruction memory. The core only reads IMEM; this block fills it.
- Accepts a byte stream from a host or debug port using a valid/ready handshake.
- Assembles the bytes into instruction words and writes them into IMEM sequentially from address 0.
- Holds the core in reset while loading and releases it only after a successful load.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_word_assembler.sv | 61 ++++++
 rtl/imem_loader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  function automatic int bytes_per_word(input int instr_width);
    return instr_width / BYTE_W;
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembler; word_valid pulses the cycle after the
// final byte of each word is accepted.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   byte_en,
  input  logic [BYTE_W-1:0]      byte_in,
  output logic                   last_byte,
  output logic                   word_valid,
  output logic [INSTR_WIDTH-1:0] word
);

  localparam int BPW   = bytes_per_word(INSTR_WIDTH);
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPW - 1);

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [INSTR_WIDTH-1:0] word_q, word_d;
  logic                   word_valid_q, word_valid_d;

  assign last_byte  = (cnt_q == CNT_LAST);
  assign word_valid = word_valid_q;
  assign word       = word_q;

  always_comb begin
    cnt_d        = cnt_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clr) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (byte_en) begin
      // byte position equals the count, so the first byte lands lowest
      word_d[int'(cnt_q)*BYTE_W +: BYTE_W] = byte_in;
      if (cnt_q == CNT_LAST) begin
        cnt_d        = '0;
        word_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// IMEM writer: length byte, N little-endian words, then an XOR checksum byte
// when IMEM_LOADER_CSUM_EN is defined. Holds the core until a good load.
//
// state | meaning
// IDLE  | after reset, core not held, waiting for start
// LEN   | waiting for the length byte
// DATA  | receiving payload bytes, writing words to IMEM
// CSUM  | waiting for the checksum byte (checksum build only)
// DONE  | last load good, core released
// ERR   | last load bad, core held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = 16,
  parameter int IMEM_DEPTH  = 4,
  parameter int ADDR_WIDTH  = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_waddr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   core_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [7:0] MAX_LEN = 8'(IMEM_DEPTH);

`ifdef IMEM_LOADER_CSUM_EN
  localparam state_e ST_PAYLOAD_END = ST_CSUM;
  logic [7:0] csum_q, csum_d;
`else
  localparam state_e ST_PAYLOAD_END = ST_DONE;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            words_left_q, words_left_d;
  logic                  s_ready_q, s_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  core_hold_q, core_hold_d;

  logic                   xfer, start_take, asm_en, asm_last, asm_valid;
  logic [INSTR_WIDTH-1:0] asm_word;

  assign xfer       = s_valid && s_ready_q;
  assign start_take = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign asm_en     = xfer && (state_q == ST_DATA);

  imem_loader_word_assembler #(
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_take),
    .byte_en   (asm_en),
    .byte_in   (s_data),
    .last_byte (asm_last),
    .word_valid(asm_valid),
    .word      (asm_word)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d       = csum_q;
`endif
    // advance only while words remain, so the final address stays at N-1
    if (asm_valid && (words_left_q != 8'd0)) addr_d = addr_q + ADDR_WIDTH'(1);

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d      = ST_LEN;
          addr_d       = '0;
          words_left_d = '0;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d       = '0;
`endif
        end
      end
      ST_LEN: begin
        if (xfer) begin
          if ((s_data == 8'd0) || (s_data > MAX_LEN)) begin
            state_d = ST_ERR;
          end else begin
            words_left_d = s_data;
            state_d      = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
`ifdef IMEM_LOADER_CSUM_EN
          csum_d = csum_q ^ s_data;
`endif
          if (asm_last) begin
            words_left_d = words_left_q - 8'd1;
            if (words_left_q == 8'd1) state_d = ST_PAYLOAD_END;
          end
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      ST_CSUM: begin
        if (xfer) state_d = (s_data == csum_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    s_ready_d   = state_d inside {ST_LEN, ST_DATA, ST_CSUM};
    busy_d      = state_d inside {ST_LEN, ST_DATA, ST_CSUM};
    core_hold_d = state_d inside {ST_LEN, ST_DATA, ST_CSUM, ST_ERR};
    done_d      = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      words_left_q <= '0;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_hold_q  <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      s_ready_q    <= s_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      core_hold_q  <= core_hold_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign s_ready    = s_ready_q;
  assign imem_we    = asm_valid;
  assign imem_waddr = addr_q;
  assign imem_wdata = asm_word;
  assign core_hold  = core_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
